test_block: RTL and testbench
=============================

TEST_BLOCK -- requirements
Module: test_block

Interface
REQ-001 Parameter: OUT_RESET, default 1'b0, value forced onto OUT_o and on both INPA history bits while reset is asserted.
REQ-002 clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-004 FUNC  input  32  truth table; bit n is the output value for index n.
REQ-005 A  input  2  table bank select; forms the top two index bits.
REQ-006 INPA_i  input  1  data input, sampled each clock.
REQ-007 OUT_o  output  1  registered table output.

Function
REQ-008 Internal state: inpa_d1 and inpa_d2, a 2-stage shift register of INPA_i; each edge, inpa_d1 takes INPA_i and inpa_d2 takes inpa_d1.
REQ-009 Index is a 5-bit value: idx = {A[1:0], inpa_d2, inpa_d1, INPA_i}, with A[1] as MSB and INPA_i as LSB.
REQ-010 Each rising edge, OUT_o takes FUNC[idx], using the values of FUNC, A, INPA_i, inpa_d1 and inpa_d2 present before that edge.
REQ-011 Latency:
- A change on FUNC, A or INPA_i is visible on OUT_o after exactly 1 clock.
- An INPA_i value contributes to idx bit1 one cycle after it is sampled and to idx bit2 two cycles after.
REQ-012 FUNC and A are used combinationally each cycle; no write strobe and no shadow register; a change applies on the next edge.
REQ-013 All 32 FUNC bits are reachable; no index value is reserved or invalid.
REQ-014 Simultaneous changes of FUNC, A and INPA_i in one cycle are all applied on the same edge; there is no priority.
REQ-015 OUT_o is driven directly from a flip-flop; there is no combinational path from inputs to OUT_o.

Reset
REQ-016 While rst_n_i = 0, OUT_o, inpa_d1 and inpa_d2 equal OUT_RESET immediately, without waiting for clk_i.
REQ-017 Reset asserted mid-operation discards the INPA history.
REQ-018 After rst_n_i rises, the first rising edge computes idx with both history bits equal to OUT_RESET.
REQ-019 There is no other initialisation; the block is fully operational on the first edge after reset release.

Verification
REQ-020 Reset values:
- Stimulus: rst_n_i = 0, FUNC = 0xFFFFFFFF, INPA_i toggling.
- Response: OUT_o = 0 throughout; after release with INPA_i = 0 and A = 0, OUT_o = 1 from the first edge.
REQ-021 Index 0 vs index 1:
- Stimulus: FUNC = 0x00000001, A = 0, INPA_i = 0, out of reset.
- Response: OUT_o = 1.
- Stimulus: set INPA_i = 1.
- Response: OUT_o = 0 one cycle later (idx = 1).
REQ-022 History pipeline:
- Stimulus: FUNC = 0x00000004, A = 0, single-cycle INPA_i pulse sampled at edge t.
- Response: OUT_o = 1 only after edge t+1 (idx = 2); 0 after edges t and t+2 (idx 1 and 4).
REQ-023 Bank select:
- Stimulus: FUNC = 0x01000000, INPA_i = 0 steady.
- Response: A = 3 gives OUT_o = 1 (idx = 24); A = 2 gives OUT_o = 0 (idx = 16), each one cycle after the A change.
REQ-024 Asynchronous reset:
- Stimulus: OUT_o = 1, then rst_n_i pulsed low between clock edges.
- Response: OUT_o goes to 0 before the next edge; history is cleared, checked via FUNC = 0x00000004 not firing on the first post-reset edge with INPA_i = 0.
REQ-025 FUNC update:
- Stimulus: FUNC changed 0x00000000 -> 0xFFFFFFFF with A and INPA_i held.
- Response: OUT_o goes 0 -> 1 exactly one edge later.

Source files
------------

// File: rtl/test_block.sv
// -----------------------------------------------------------------------------
// test_block
//
// Registered 32-entry lookup. Each rising clock edge, the output flop loads one
// bit of a 32-bit truth table. The 5-bit index is built from the bank select
// and the last three samples of the data input:
//
//   idx = {A[1:0], inpa_d2, inpa_d1, INPA_i}    (A[1] is MSB, INPA_i is LSB)
//
// The table and bank select are read combinationally each cycle. There is no
// write strobe and no shadow copy, so a change applies on the next edge.
//
// Ports
//   clk_i    in   1   system clock, rising edge
//   rst_n_i  in   1   asynchronous active-low reset
//   FUNC     in  32   truth table; bit n is the output for index n
//   A        in   2   bank select, top two index bits
//   INPA_i   in   1   data input, sampled every clock
//   OUT_o    out  1   registered table output
//
// Parameter
//   OUT_RESET  value held on OUT_o and on both history bits during reset
// -----------------------------------------------------------------------------
module test_block #(
    parameter logic OUT_RESET = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] FUNC,
    input  logic [1:0]  A,
    input  logic        INPA_i,
    output logic        OUT_o
);

    // Two-deep history of INPA_i: inpa_d1 is one edge old, inpa_d2 is two.
    logic       inpa_d1;
    logic       inpa_d2;
    logic [4:0] idx;

    assign idx = {A, inpa_d2, inpa_d1, INPA_i};

    // Reset forces the output and both history bits to OUT_RESET, so the
    // first edge after release sees a known history and no stale samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            OUT_o   <= OUT_RESET;
            inpa_d1 <= OUT_RESET;
            inpa_d2 <= OUT_RESET;
        end else begin
            OUT_o   <= FUNC[idx];
            inpa_d1 <= INPA_i;
            inpa_d2 <= inpa_d1;
        end
    end

endmodule

// File: tb/tb_test_block.sv
// -----------------------------------------------------------------------------
// tb_test_block
//
// Self-checking bench for test_block. Directed scenarios check fixed values;
// the randomized scenario compares against a reference model that keeps the
// sampled INPA values in a queue and looks the index up arithmetically.
// -----------------------------------------------------------------------------
module tb_test_block;

    localparam logic OUT_RESET = 1'b0;

    logic        clk;
    logic        rst_n;
    logic [31:0] func;
    logic [1:0]  a;
    logic        inpa;
    logic        out;

    int checks = 0;
    int errors = 0;

    // Reference history: element 0 is the newest sample, element 1 the older.
    int hist[$];

    test_block #(.OUT_RESET(OUT_RESET)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .FUNC    (func),
        .A       (a),
        .INPA_i  (inpa),
        .OUT_o   (out)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        hist.delete();
        hist.push_back(int'(OUT_RESET));
        hist.push_back(int'(OUT_RESET));
    endtask

    // Advance one rising edge. Returns the value the output should hold
    // afterwards, computed from the inputs present before the edge.
    task automatic step(output logic exp_out);
        int  idx;
        logic r;
        r = rst_n;
        if (!r) begin
            exp_out = OUT_RESET;
        end else begin
            idx = int'(a) * 8 + hist[1] * 4 + hist[0] * 2 + int'(inpa);
            exp_out = func[idx];
        end
        @(posedge clk);
        #1;
        if (r) begin
            hist.push_front(int'(inpa));
            void'(hist.pop_back());
        end else begin
            model_reset();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic e;
        rst_n = 1'b0;
        func  = 32'hFFFF_FFFF;
        a     = 2'd0;
        inpa  = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got %b want 0", out);
        end
        for (int i = 0; i < 4; i++) begin
            inpa = ~inpa;
            step(e);
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d] got %b want 0", i, out);
            end
        end
        inpa  = 1'b0;
        rst_n = 1'b1;
        step(e);
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got %b want 1", out);
        end
    endtask

    task automatic test_index01();
        logic e;
        func = 32'h0000_0001;
        a    = 2'd0;
        inpa = 1'b0;
        step(e);
        step(e);
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL idx0 got %b want 1", out);
        end
        inpa = 1'b1;
        step(e);
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL idx1 got %b want 0", out);
        end
    endtask

    task automatic test_history();
        logic e;
        logic want[4];
        func = 32'h0000_0004;
        a    = 2'd0;
        inpa = 1'b0;
        step(e);
        step(e);
        step(e);
        // Pulse sampled at edge t: idx 1, then 2, then 4, then 0.
        want[0] = 1'b0;
        want[1] = 1'b1;
        want[2] = 1'b0;
        want[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inpa = (i == 0);
            step(e);
            checks++;
            if (out !== want[i]) begin
                errors++;
                $display("FAIL history t+%0d got %b want %b", i, out, want[i]);
            end
        end
    endtask

    task automatic test_bank();
        logic e;
        func = 32'h0100_0000;
        inpa = 1'b0;
        a    = 2'd0;
        step(e);
        step(e);
        a = 2'd3;
        step(e);
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL bank_a3 got %b want 1", out);
        end
        a = 2'd2;
        step(e);
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL bank_a2 got %b want 0", out);
        end
    endtask

    task automatic test_async_reset();
        logic e;
        func = 32'hFFFF_FFFF;
        a    = 2'd0;
        inpa = 1'b0;
        step(e);
        inpa = 1'b1;
        step(e);
        // History now holds d1=1, d2=0; output is 1.
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got %b want 1", out);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL areset_async got %b want 0", out);
        end
        #1;
        rst_n = 1'b1;
        func  = 32'h0000_0004;
        inpa  = 1'b0;
        step(e);
        // Stale d1=1 would give idx 2 and fire; cleared history gives idx 0.
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL areset_history got %b want 0", out);
        end
    endtask

    task automatic test_func_update();
        logic e;
        a    = 2'd1;
        inpa = 1'b1;
        func = 32'h0000_0000;
        step(e);
        step(e);
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL func_zero got %b want 0", out);
        end
        func = 32'hFFFF_FFFF;
        step(e);
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL func_ones got %b want 1", out);
        end
    endtask

    task automatic test_random();
        logic e;
        for (int i = 0; i < 300; i++) begin
            func = $urandom;
            a    = 2'($urandom_range(0, 3));
            inpa = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                // Mid-cycle reset pulse.
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                checks++;
                if (out !== OUT_RESET) begin
                    errors++;
                    $display("FAIL rand_reset[%0d] got %b want %b", i, out, OUT_RESET);
                end
                rst_n = 1'b1;
            end
            step(e);
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL rand[%0d] got %b want %b", i, out, e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_index01();
        test_history();
        test_bank();
        test_async_reset();
        test_func_update();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
